// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic unit.
//   state_e   : control FSM states
//   cnt_width : bit counter width for a given operand width
//   ModeAdd / ModeSub : encoding of the sub mode input
package serial_arith_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam logic ModeAdd = 1'b0;
    localparam logic ModeSub = 1'b1;

    // One extra bit so the counter can never wrap within an operation.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/fa_mux_cell.sv
// Combinational 1-bit full adder built only from 2:1 multiplexers.
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   sum   : a ^ b ^ cin
//   cout  : majority(a, b, cin)
module fa_mux_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic prop;

    // prop = a ^ b; when the bits differ the carry propagates, otherwise it equals a (== b).
    assign prop = a ? ~b : b;
    assign sum  = prop ? ~cin : cin;
    assign cout = prop ? cin : a;

endmodule

// File: rtl/serial_adder_sub.sv
// Bit-serial add/subtract unit. Operands are captured on an accepted start, then processed
// LSB-first one bit per clock through a single mux-based full-adder cell.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : operation request, only honoured in idle
//   a, b, cin  : operands and carry-in (cin ignored when subtracting)
//   sub        : 0 = a + b + cin, 1 = a - b
//   busy       : high while bits are being processed
//   done       : one-cycle pulse, results valid from this cycle
//   sum        : result, held until the next accepted start
//   cout       : add carry-out, or subtract no-borrow
//   ovf        : signed overflow
module serial_adder_sub
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic cell_sum;
    logic cell_cout;

    fa_mux_cell u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (cell_sum),
        .cout (cell_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        // Subtraction is A + ~B + 1: invert B and force the initial carry.
                        b_q     <= (sub == ModeSub) ? ~b : b;
                        carry_q <= (sub == ModeSub) ? 1'b1 : cin;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    sum_q   <= {cell_sum, sum_q[WIDTH-1:1]};
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= cell_cout;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LastBit) begin
                        // carry_q still holds the carry into the MSB here.
                        cout_q  <= cell_cout;
                        ovf_q   <= carry_q ^ cell_cout;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_sub.sv
// Self-checking bench for serial_adder_sub at WIDTH = 8, 2 and 3, against an arithmetic model.
module tb_serial_adder_sub;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start2, start3;
    logic [63:0] a_in, b_in;
    logic        cin_in, sub_in;

    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;
    logic       busy2, done2, cout2, ovf2;
    logic [1:0] sum2;
    logic       busy3, done3, cout3, ovf3;
    logic [2:0] sum3;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    serial_adder_sub #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a_in[7:0]), .b(b_in[7:0]),
        .cin(cin_in), .sub(sub_in), .busy(busy8), .done(done8), .sum(sum8),
        .cout(cout8), .ovf(ovf8)
    );

    serial_adder_sub #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a_in[1:0]), .b(b_in[1:0]),
        .cin(cin_in), .sub(sub_in), .busy(busy2), .done(done2), .sum(sum2),
        .cout(cout2), .ovf(ovf2)
    );

    serial_adder_sub #(.WIDTH(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .a(a_in[2:0]), .b(b_in[2:0]),
        .cin(cin_in), .sub(sub_in), .busy(busy3), .done(done3), .sum(sum3),
        .cout(cout3), .ovf(ovf3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output views selected by width.
    function automatic logic get_busy(input int w);
        return (w == 2) ? busy2 : (w == 3) ? busy3 : busy8;
    endfunction
    function automatic logic get_done(input int w);
        return (w == 2) ? done2 : (w == 3) ? done3 : done8;
    endfunction
    function automatic logic [63:0] get_sum(input int w);
        return (w == 2) ? 64'(sum2) : (w == 3) ? 64'(sum3) : 64'(sum8);
    endfunction
    function automatic logic get_cout(input int w);
        return (w == 2) ? cout2 : (w == 3) ? cout3 : cout8;
    endfunction
    function automatic logic get_ovf(input int w);
        return (w == 2) ? ovf2 : (w == 3) ? ovf3 : ovf8;
    endfunction

    task automatic set_start(input int w, input logic v);
        start2 = (w == 2) ? v : 1'b0;
        start3 = (w == 3) ? v : 1'b0;
        start8 = (w == 8) ? v : 1'b0;
    endtask

    function automatic longint sext(input longint v, input int w);
        return (v >= (longint'(1) << (w - 1))) ? v - (longint'(1) << w) : v;
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    task automatic model(input int w, input longint av, input longint bv, input logic ci,
                         input logic sb, output longint es, output logic ec, output logic eo);
        longint m, full, sr;
        m = longint'(1) << w;
        if (sb) begin
            full = av - bv;
            ec   = (av >= bv);
            sr   = sext(av, w) - sext(bv, w);
        end else begin
            full = av + bv + longint'(ci);
            ec   = (full >= m);
            sr   = sext(av, w) + sext(bv, w) + longint'(ci);
        end
        es = ((full % m) + m) % m;
        eo = (sr > (m / 2 - 1)) || (sr < -(m / 2));
    endtask

    // One full operation: issue, wait for done with a bound, check result, latency and pulse.
    task automatic do_op(input int w, input longint av, input longint bv, input logic ci,
                         input logic sb, input string tag);
        longint    es;
        logic      ec, eo;
        int        cycles, busy_cnt;
        logic [63:0] held;
        model(w, av, bv, ci, sb, es, ec, eo);
        a_in   = 64'(av);
        b_in   = 64'(bv);
        cin_in = ci;
        sub_in = sb;
        set_start(w, 1'b1);
        tick();
        set_start(w, 1'b0);
        cycles   = 0;
        busy_cnt = 0;
        while (!get_done(w) && cycles < 4 * w + 8) begin
            if (get_busy(w)) busy_cnt++;
            // Operand inputs are don't-care once captured.
            a_in   = {$urandom, $urandom};
            b_in   = {$urandom, $urandom};
            cin_in = 1'($urandom);
            sub_in = 1'($urandom);
            tick();
            cycles++;
        end
        check($sformatf("%s latency", tag), 64'(cycles), 64'(w));
        check($sformatf("%s busy_cycles", tag), 64'(busy_cnt), 64'(w));
        check($sformatf("%s sum", tag), get_sum(w), 64'(es));
        check($sformatf("%s cout", tag), 64'(get_cout(w)), 64'(ec));
        check($sformatf("%s ovf", tag), 64'(get_ovf(w)), 64'(eo));
        check($sformatf("%s busy_at_done", tag), 64'(get_busy(w)), 64'(0));
        held = get_sum(w);
        tick();
        check($sformatf("%s done_pulse", tag), 64'(get_done(w)), 64'(0));
        check($sformatf("%s sum_held", tag), get_sum(w), held);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int     done_seen;
        logic [63:0] cap_sum;
        rst = 1'b1;
        set_start(8, 1'b0);
        a_in = '0; b_in = '0; cin_in = 1'b0; sub_in = 1'b0;
        tick();
        tick();
        check("reset busy", 64'(busy8), 64'(0));
        check("reset done", 64'(done8), 64'(0));
        check("reset sum", 64'(sum8), 64'(0));
        check("reset cout", 64'(cout8), 64'(0));
        check("reset ovf", 64'(ovf8), 64'(0));
        check("reset w2 sum", 64'(sum2), 64'(0));
        rst = 1'b0;
        tick();

        // Directed boundary cases.
        do_op(8, 'hFF, 'h01, 1'b0, 1'b0, "add_ff_01");
        do_op(8, 'h7F, 'h01, 1'b0, 1'b0, "add_7f_01");
        do_op(8, 'h10, 'h20, 1'b1, 1'b0, "add_10_20_c");
        do_op(8, 'h05, 'h07, 1'b0, 1'b1, "sub_05_07");
        do_op(8, 'h80, 'h01, 1'b0, 1'b1, "sub_80_01");
        do_op(8, 'h80, 'h01, 1'b1, 1'b1, "sub_80_01_cin");
        do_op(8, 'h05, 'h07, 1'b1, 1'b1, "sub_05_07_cin");

        // Restarts during RUN/DONE are ignored.
        a_in = 'h12; b_in = 'h34; cin_in = 1'b0; sub_in = 1'b0;
        set_start(8, 1'b1);
        tick();
        done_seen = 0;
        cap_sum   = '0;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            if (done8) begin
                done_seen++;
                cap_sum = 64'(sum8);
            end
            a_in   = {$urandom, $urandom};
            b_in   = {$urandom, $urandom};
            sub_in = 1'b1;
            set_start(8, (cyc == 3 || cyc == 8));
            tick();
        end
        set_start(8, 1'b0);
        check("restart done_count", 64'(done_seen), 64'(1));
        check("restart sum", cap_sum, 64'h46);
        check("restart idle_done", 64'(done8), 64'(0));
        do_op(8, 'h33, 'h44, 1'b0, 1'b0, "after_done");

        // Reset mid-operation discards the partial result.
        a_in = 'hAA; b_in = 'h55; cin_in = 1'b1; sub_in = 1'b0;
        set_start(8, 1'b1);
        tick();
        set_start(8, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset busy", 64'(busy8), 64'(0));
        check("midreset done", 64'(done8), 64'(0));
        check("midreset sum", 64'(sum8), 64'(0));
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8) done_seen++;
            tick();
        end
        check("midreset no_done", 64'(done_seen), 64'(0));
        do_op(8, 'hC3, 'h3C, 1'b0, 1'b1, "post_reset");

        // Random 8-bit operations.
        for (int i = 0; i < 30; i++) begin
            do_op(8, longint'($urandom_range(255)), longint'($urandom_range(255)),
                  1'($urandom), 1'($urandom), $sformatf("rand8_%0d", i));
        end

        // Exhaustive small widths.
        for (int w = 2; w <= 3; w++) begin
            for (int av = 0; av < (1 << w); av++) begin
                for (int bv = 0; bv < (1 << w); bv++) begin
                    for (int m = 0; m < 4; m++) begin
                        do_op(w, longint'(av), longint'(bv), m[0], m[1],
                              $sformatf("w%0d_%0d_%0d_c%0d_s%0d", w, av, bv, m[0], m[1]));
                    end
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
